branch_issue_queue: RTL and testbench

//  In-order issue queue and scheduler in front of the branch execution unit (BEU).

---
 rtl/branch_issue_queue_pkg.sv | 64 ++++++
 rtl/branch_issue_queue_biq_entry.sv | 66 ++++++
 rtl/branch_issue_queue.sv | 129 ++++++++++++
 tb/tb_branch_issue_queue.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_issue_queue_pkg.sv
// Shared types, constants and helpers for the branch issue queue.
// Optional feature macro: BIQ_BYPASS_EN (writeback-to-issue bypass on the head).
`ifndef SCOREBOARD_SIZE_WIDTH
`define SCOREBOARD_SIZE_WIDTH 4
`endif

package branch_issue_queue_pkg;
   localparam int BIQ_DEPTH = 4;
   localparam int SID_W     = `SCOREBOARD_SIZE_WIDTH + 1;

   localparam logic [3:0] FC_JAL  = 4'b0111;
   localparam logic [3:0] FC_JALR = 4'b0101;
   localparam logic [3:0] FC_BR   = 4'b0100;

   // Fields of a queued op that travel unchanged to the BEU
   typedef struct packed {
      logic [63:0]      pc;
      logic [31:0]      inst;
      logic [SID_W-1:0] sid;
      logic [3:0]       func_code;
   } biq_op_t;

   // One source operand: ready flag, producer id, captured value
   typedef struct packed {
      logic             rdy;
      logic [SID_W-1:0] sid;
      logic [63:0]      value;
   } biq_src_t;

   typedef struct packed {
      logic     valid;
      biq_op_t  op;
      biq_src_t src1;
      biq_src_t src2;
   } biq_entry_t;

   typedef struct packed {
      logic     valid;
      biq_op_t  op;
      logic [63:0] rs1;
      logic [63:0] rs2;
   } biq_issue_t;

   // True when a still-waiting source is produced by the current writeback
   function automatic logic src_hit(input biq_src_t s, input logic wb_valid,
                                    input logic [SID_W-1:0] wb_sid);
      return !s.rdy && wb_valid && (s.sid == wb_sid);
   endfunction

   // Source after capturing the current writeback, if it matches
   function automatic biq_src_t src_wake(input biq_src_t s, input logic wb_valid,
                                         input logic [SID_W-1:0] wb_sid,
                                         input logic [63:0] wb_value);
      biq_src_t r;
      r = s;
      if (src_hit(s, wb_valid, wb_sid)) begin
         r.rdy   = 1'b1;
         r.value = wb_value;
      end else begin
         r = s;
      end
      return r;
   endfunction
endpackage

// File: rtl/branch_issue_queue_biq_entry.sv
// One issue-queue slot: op fields, two operand triples and their wakeup.
// With BIQ_BYPASS_EN the slot also reports readiness/values including this cycle's writeback.
module biq_entry
   import branch_issue_queue_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             load_i,
   input  logic             pop_i,
   input  biq_op_t          load_op_i,
   input  biq_src_t         load_src1_i,
   input  biq_src_t         load_src2_i,
   input  logic             wb_valid_i,
   input  logic [SID_W-1:0] wb_sid_i,
   input  logic [63:0]      wb_value_i,
   output logic             issue_ok_o,
   output biq_op_t          op_o,
   output logic [63:0]      rs1_o,
   output logic [63:0]      rs2_o
);
   biq_entry_t ent_d, ent_q;

   // Readiness and operand values presented to the select logic
   always_comb begin
      op_o = ent_q.op;
`ifdef BIQ_BYPASS_EN
      issue_ok_o = ent_q.valid
                 & (ent_q.src1.rdy | src_hit(ent_q.src1, wb_valid_i, wb_sid_i))
                 & (ent_q.src2.rdy | src_hit(ent_q.src2, wb_valid_i, wb_sid_i));
      rs1_o = ent_q.src1.rdy ? ent_q.src1.value : wb_value_i;
      rs2_o = ent_q.src2.rdy ? ent_q.src2.value : wb_value_i;
`else
      issue_ok_o = ent_q.valid & ent_q.src1.rdy & ent_q.src2.rdy;
      rs1_o = ent_q.src1.value;
      rs2_o = ent_q.src2.value;
`endif
   end

   // Slot update: clear on kill, fill on enqueue (with same-cycle wakeup), free on issue, else wake
   always_comb begin
      ent_d = ent_q;
      if (clr_i) begin
         ent_d.valid = 1'b0;
      end else if (load_i) begin
         ent_d.valid = 1'b1;
         ent_d.op    = load_op_i;
         ent_d.src1  = src_wake(load_src1_i, wb_valid_i, wb_sid_i, wb_value_i);
         ent_d.src2  = src_wake(load_src2_i, wb_valid_i, wb_sid_i, wb_value_i);
      end else if (pop_i) begin
         ent_d.valid = 1'b0;
      end else begin
         ent_d.src1 = src_wake(ent_q.src1, wb_valid_i, wb_sid_i, wb_value_i);
         ent_d.src2 = src_wake(ent_q.src2, wb_valid_i, wb_sid_i, wb_value_i);
      end
   end

   // Slot state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ent_q <= '0;
      end else begin
         ent_q <= ent_d;
      end
   end
endmodule

// File: rtl/branch_issue_queue.sv
// In-order branch issue queue feeding the BEU; self-flushes on redirect/flush.
// Optional feature macro: BIQ_BYPASS_EN (head may issue in the same cycle as its last wakeup).
module branch_issue_queue
   import branch_issue_queue_pkg::*;
#(
   parameter int DEPTH = BIQ_DEPTH,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush_i,
   input  logic             disp_valid_i,
   output logic             disp_ready_o,
   input  logic [63:0]      disp_pc_i,
   input  logic [31:0]      disp_inst_i,
   input  logic [SID_W-1:0] disp_sid_i,
   input  logic [3:0]       disp_func_code_i,
   input  logic             disp_rs1_rdy_i,
   input  logic [63:0]      disp_rs1_value_i,
   input  logic [SID_W-1:0] disp_rs1_sid_i,
   input  logic             disp_rs2_rdy_i,
   input  logic [63:0]      disp_rs2_value_i,
   input  logic [SID_W-1:0] disp_rs2_sid_i,
   input  logic             wb_valid_i,
   input  logic [SID_W-1:0] wb_sid_i,
   input  logic [63:0]      wb_value_i,
   input  logic             branch_redirect_i,
   output logic             branch_valid_o,
   output logic [63:0]      branch_pc_o,
   output logic [31:0]      branch_inst_o,
   output logic [SID_W-1:0] branch_sid_o,
   output logic [3:0]       branch_func_code_o,
   output logic [63:0]      rs1_value_o,
   output logic [63:0]      rs2_value_o,
   output logic [PTR_W:0]   biq_count_o
);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [PTR_W-1:0] head_d, head_q, tail_d, tail_q;
   logic [PTR_W:0]   count_d, count_q;
   biq_issue_t       iss_d, iss_q;

   logic             kill_s, ready_s, enq_s, sel_s;
   biq_op_t          disp_op_s;
   biq_src_t         disp_src1_s, disp_src2_s;
   logic [DEPTH-1:0] ok_s;
   biq_op_t          op_s  [DEPTH];
   logic [63:0]      rs1_s [DEPTH];
   logic [63:0]      rs2_s [DEPTH];

   // Accept/select decisions and dispatch packing
   always_comb begin
      kill_s  = flush_i | branch_redirect_i;
      ready_s = (count_q != FULL_CNT) & !kill_s;
      enq_s   = disp_valid_i & ready_s;
      sel_s   = ok_s[head_q] & !kill_s;
      disp_op_s   = '{pc: disp_pc_i, inst: disp_inst_i, sid: disp_sid_i,
                      func_code: disp_func_code_i};
      disp_src1_s = '{rdy: disp_rs1_rdy_i, sid: disp_rs1_sid_i, value: disp_rs1_value_i};
      disp_src2_s = '{rdy: disp_rs2_rdy_i, sid: disp_rs2_sid_i, value: disp_rs2_value_i};
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_ent
      biq_entry u_ent (
         .clk         (clk),
         .rst_n       (rst_n),
         .clr_i       (kill_s),
         .load_i      (enq_s && (tail_q == PTR_W'(i))),
         .pop_i       (sel_s && (head_q == PTR_W'(i))),
         .load_op_i   (disp_op_s),
         .load_src1_i (disp_src1_s),
         .load_src2_i (disp_src2_s),
         .wb_valid_i  (wb_valid_i),
         .wb_sid_i    (wb_sid_i),
         .wb_value_i  (wb_value_i),
         .issue_ok_o  (ok_s[i]),
         .op_o        (op_s[i]),
         .rs1_o       (rs1_s[i]),
         .rs2_o       (rs2_s[i])
      );
   end

   // Pointer, count and issue-register next state
   always_comb begin
      iss_d       = iss_q;
      iss_d.valid = sel_s;
      if (sel_s) begin
         iss_d.op  = op_s[head_q];
         iss_d.rs1 = rs1_s[head_q];
         iss_d.rs2 = rs2_s[head_q];
      end else begin
         iss_d.op  = iss_q.op;
      end
      if (kill_s) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         head_d  = head_q + PTR_W'(sel_s);
         tail_d  = tail_q + PTR_W'(enq_s);
         count_d = count_q + (PTR_W+1)'(enq_s) - (PTR_W+1)'(sel_s);
      end
   end

   // Queue control and issue registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         iss_q   <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         iss_q   <= iss_d;
      end
   end

   assign disp_ready_o       = ready_s;
   assign branch_valid_o     = iss_q.valid;
   assign branch_pc_o        = iss_q.op.pc;
   assign branch_inst_o      = iss_q.op.inst;
   assign branch_sid_o       = iss_q.op.sid;
   assign branch_func_code_o = iss_q.op.func_code;
   assign rs1_value_o        = iss_q.rs1;
   assign rs2_value_o        = iss_q.rs2;
   assign biq_count_o        = count_q;
endmodule

// File: tb/tb_branch_issue_queue.sv
// Self-checking bench for branch_issue_queue: queue-level reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_branch_issue_queue;
   import branch_issue_queue_pkg::*;

   logic clk = 1'b0, rst_n;
   logic flush_i, disp_valid_i, disp_ready_o;
   logic [63:0] disp_pc_i;
   logic [31:0] disp_inst_i;
   logic [SID_W-1:0] disp_sid_i, disp_rs1_sid_i, disp_rs2_sid_i, wb_sid_i, branch_sid_o;
   logic [3:0] disp_func_code_i, branch_func_code_o;
   logic disp_rs1_rdy_i, disp_rs2_rdy_i, wb_valid_i, branch_redirect_i, branch_valid_o;
   logic [63:0] disp_rs1_value_i, disp_rs2_value_i, wb_value_i;
   logic [63:0] branch_pc_o, rs1_value_o, rs2_value_o;
   logic [31:0] branch_inst_o;
   logic [2:0] biq_count_o;

   branch_issue_queue dut (
      .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
      .disp_valid_i(disp_valid_i), .disp_ready_o(disp_ready_o),
      .disp_pc_i(disp_pc_i), .disp_inst_i(disp_inst_i), .disp_sid_i(disp_sid_i),
      .disp_func_code_i(disp_func_code_i),
      .disp_rs1_rdy_i(disp_rs1_rdy_i), .disp_rs1_value_i(disp_rs1_value_i),
      .disp_rs1_sid_i(disp_rs1_sid_i),
      .disp_rs2_rdy_i(disp_rs2_rdy_i), .disp_rs2_value_i(disp_rs2_value_i),
      .disp_rs2_sid_i(disp_rs2_sid_i),
      .wb_valid_i(wb_valid_i), .wb_sid_i(wb_sid_i), .wb_value_i(wb_value_i),
      .branch_redirect_i(branch_redirect_i),
      .branch_valid_o(branch_valid_o), .branch_pc_o(branch_pc_o),
      .branch_inst_o(branch_inst_o), .branch_sid_o(branch_sid_o),
      .branch_func_code_o(branch_func_code_o),
      .rs1_value_o(rs1_value_o), .rs2_value_o(rs2_value_o),
      .biq_count_o(biq_count_o)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct {
      logic [63:0] pc; logic [31:0] inst; logic [SID_W-1:0] sid; logic [3:0] fc;
      logic r1rdy; logic [SID_W-1:0] r1sid; logic [63:0] r1v;
      logic r2rdy; logic [SID_W-1:0] r2sid; logic [63:0] r2v;
   } op_t;

   op_t q[$];
   logic exp_valid;
   logic [63:0] exp_pc, exp_rs1, exp_rs2;
   logic [31:0] exp_inst;
   logic [SID_W-1:0] exp_sid;
   logic [3:0] exp_fc;
   int n_cmp = 0, n_err = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic op_t wake(input op_t o);
      op_t r = o;
      if (wb_valid_i && !r.r1rdy && r.r1sid == wb_sid_i) begin r.r1rdy = 1'b1; r.r1v = wb_value_i; end
      if (wb_valid_i && !r.r2rdy && r.r2sid == wb_sid_i) begin r.r2rdy = 1'b1; r.r2v = wb_value_i; end
      return r;
   endfunction

   task automatic model_reset();
      q.delete();
      exp_valid = 1'b0; exp_pc = '0; exp_inst = '0; exp_sid = '0;
      exp_fc = '0; exp_rs1 = '0; exp_rs2 = '0;
   endtask

   // Advance the model by one clock edge using the inputs that were applied at that edge
   task automatic model_step();
      bit kill, acc, iss;
      op_t h, n;
      logic r1, r2;
      logic [63:0] v1, v2;
      if (!rst_n) begin model_reset(); return; end
      kill = flush_i || branch_redirect_i;
      acc  = !kill && q.size() < 4 && disp_valid_i;
      iss  = 1'b0;
      if (!kill && q.size() > 0) begin
         h = q[0];
         r1 = h.r1rdy; v1 = h.r1v; r2 = h.r2rdy; v2 = h.r2v;
`ifdef BIQ_BYPASS_EN
         if (!r1 && wb_valid_i && h.r1sid == wb_sid_i) begin r1 = 1'b1; v1 = wb_value_i; end
         if (!r2 && wb_valid_i && h.r2sid == wb_sid_i) begin r2 = 1'b1; v2 = wb_value_i; end
`endif
         iss = r1 && r2;
      end
      exp_valid = iss;
      if (iss) begin
         exp_pc = h.pc; exp_inst = h.inst; exp_sid = h.sid; exp_fc = h.fc;
         exp_rs1 = v1; exp_rs2 = v2;
      end
      if (kill) q.delete();
      else begin
         if (iss) q.delete(0);
         foreach (q[i]) q[i] = wake(q[i]);
         if (acc) begin
            n = '{pc: disp_pc_i, inst: disp_inst_i, sid: disp_sid_i, fc: disp_func_code_i,
                  r1rdy: disp_rs1_rdy_i, r1sid: disp_rs1_sid_i, r1v: disp_rs1_value_i,
                  r2rdy: disp_rs2_rdy_i, r2sid: disp_rs2_sid_i, r2v: disp_rs2_value_i};
            q.push_back(wake(n));
         end
      end
   endtask

   // Every-cycle comparison of the DUT against the model, away from the active edge
   always @(negedge clk) begin
      if (chk_en) begin
         check("ready", disp_ready_o, 64'(q.size() != 4 && !flush_i && !branch_redirect_i));
         check("count", biq_count_o, 64'(q.size()));
         check("valid", branch_valid_o, exp_valid);
         if (exp_valid) begin
            check("pc", branch_pc_o, exp_pc);
            check("inst", branch_inst_o, exp_inst);
            check("sid", branch_sid_o, exp_sid);
            check("fc", branch_func_code_o, exp_fc);
            check("rs1", rs1_value_o, exp_rs1);
            check("rs2", rs2_value_o, exp_rs2);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic set_idle();
      flush_i = 1'b0; branch_redirect_i = 1'b0; disp_valid_i = 1'b0; wb_valid_i = 1'b0;
   endtask

   task automatic drive_disp(input logic [63:0] pc, input logic [3:0] fc,
                             input logic r1rdy, input logic [63:0] r1v, input int r1sid,
                             input logic r2rdy, input logic [63:0] r2v, input int r2sid);
      disp_valid_i = 1'b1; disp_pc_i = pc; disp_inst_i = pc[31:0] ^ 32'h5a5a0063;
      disp_sid_i = SID_W'(pc[7:0]); disp_func_code_i = fc;
      disp_rs1_rdy_i = r1rdy; disp_rs1_value_i = r1v; disp_rs1_sid_i = SID_W'(r1sid);
      disp_rs2_rdy_i = r2rdy; disp_rs2_value_i = r2v; disp_rs2_sid_i = SID_W'(r2sid);
   endtask

   task automatic drive_wb(input int sid, input logic [63:0] val);
      wb_valid_i = 1'b1; wb_sid_i = SID_W'(sid); wb_value_i = val;
   endtask

   task automatic cyc();
      @(posedge clk); #1; model_step();
   endtask

   initial begin
      rst_n = 1'b0; set_idle();
      disp_pc_i = '0; disp_inst_i = '0; disp_sid_i = '0; disp_func_code_i = '0;
      disp_rs1_rdy_i = 1'b0; disp_rs1_value_i = '0; disp_rs1_sid_i = '0;
      disp_rs2_rdy_i = 1'b0; disp_rs2_value_i = '0; disp_rs2_sid_i = '0;
      wb_sid_i = '0; wb_value_i = '0;
      model_reset();
      repeat (3) cyc();
      check("rst_valid", branch_valid_o, 64'd0);
      check("rst_count", biq_count_o, 64'd0);
      check("rst_ready", disp_ready_o, 64'd1);
      check("rst_pc", branch_pc_o, 64'd0);
      rst_n = 1'b1; chk_en = 1'b1;
      cyc();

      // 1: ready jal flows straight through
      drive_disp(64'h1000, FC_JAL, 1'b1, 64'h1, 0, 1'b1, 64'h2, 0);
      cyc(); set_idle(); cyc();
      check("t1_valid", branch_valid_o, 64'd1);
      check("t1_pc", branch_pc_o, 64'h1000);
      check("t1_count", biq_count_o, 64'd0);
      cyc();

      // 2: rs1 waits for sid 5
      drive_disp(64'h2000, FC_BR, 1'b0, 64'h0, 5, 1'b1, 64'h22, 0);
      cyc(); set_idle(); cyc();
      drive_wb(5, 64'h10); cyc(); set_idle();
`ifndef BIQ_BYPASS_EN
      check("t2_not_yet", branch_valid_o, 64'd0);
      cyc();
`endif
      check("t2_valid", branch_valid_o, 64'd1);
      check("t2_rs1", rs1_value_o, 64'h10);
      check("t2_rs2", rs2_value_o, 64'h22);
      repeat (2) cyc();

      // 3: full queue refuses dispatch even while the head wakes
      for (int i = 0; i < 4; i++) begin
         drive_disp(64'h3000 + 64'(i), FC_BR, 1'b0, 64'h0, 3, 1'b1, 64'h3, 0);
         cyc();
      end
      check("t3_count_full", biq_count_o, 64'd4);
      drive_disp(64'h3999, FC_JAL, 1'b1, 64'h0, 0, 1'b1, 64'h0, 0);
      drive_wb(3, 64'h33);
      #1 check("t3_ready_full", disp_ready_o, 64'd0);
      cyc(); set_idle();
`ifndef BIQ_BYPASS_EN
      check("t3_count_held", biq_count_o, 64'd4);
      cyc();
`endif
      #1 check("t3_count", biq_count_o, 64'd3);
      check("t3_ready", disp_ready_o, 64'd1);
      repeat (5) cyc();

      // 4: in-order issue, redirect kills the remainder
      drive_disp(64'h4a00, FC_BR, 1'b1, 64'ha, 0, 1'b1, 64'ha, 0); cyc();
      drive_disp(64'h4b00, FC_BR, 1'b1, 64'hb, 0, 1'b1, 64'hb, 0); cyc();
      check("t4_a", branch_pc_o, 64'h4a00);
      drive_disp(64'h4c00, FC_JALR, 1'b1, 64'hc, 0, 1'b1, 64'hc, 0); cyc();
      check("t4_b", branch_pc_o, 64'h4b00);
      set_idle(); branch_redirect_i = 1'b1; cyc();
      set_idle();
      check("t4_kill_valid", branch_valid_o, 64'd0);
      check("t4_kill_count", biq_count_o, 64'd0);
      repeat (2) cyc();
      check("t4_no_c", branch_valid_o, 64'd0);

      // 5: writeback in the dispatch cycle is captured
      drive_disp(64'h5000, FC_BR, 1'b1, 64'h55, 0, 1'b0, 64'h0, 7);
      drive_wb(7, 64'h77); cyc(); set_idle(); cyc();
      check("t5_valid", branch_valid_o, 64'd1);
      check("t5_rs2", rs2_value_o, 64'h77);
      cyc();

      // 6: async reset with a busy queue
      drive_disp(64'h6000, FC_BR, 1'b0, 64'h0, 9, 1'b1, 64'h6, 0); cyc();
      for (int i = 1; i < 4; i++) begin
         drive_disp(64'h6000 + 64'(i), FC_JAL, 1'b1, 64'h1, 0, 1'b1, 64'h2, 0); cyc();
      end
      set_idle(); drive_wb(9, 64'h99); cyc(); set_idle();
`ifndef BIQ_BYPASS_EN
      cyc();
`endif
      check("t6_pre_valid", branch_valid_o, 64'd1);
      check("t6_pre_count", biq_count_o, 64'd3);
      rst_n = 1'b0; model_reset();
      #1;
      check("t6_valid", branch_valid_o, 64'd0);
      check("t6_count", biq_count_o, 64'd0);
      check("t6_ready", disp_ready_o, 64'd1);
      check("t6_pc", branch_pc_o, 64'd0);
      check("t6_rs1", rs1_value_o, 64'd0);
      cyc(); rst_n = 1'b1; cyc();

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         set_idle();
         if ($urandom_range(99, 0) < 60)
            drive_disp({$urandom, $urandom}, ($urandom_range(2, 0) == 0) ? FC_JAL :
                       (($urandom_range(1, 0) == 0) ? FC_JALR : FC_BR),
                       1'($urandom_range(1, 0)), {$urandom, $urandom}, $urandom_range(7, 0),
                       1'($urandom_range(1, 0)), {$urandom, $urandom}, $urandom_range(7, 0));
         if ($urandom_range(99, 0) < 40) drive_wb($urandom_range(7, 0), {$urandom, $urandom});
         flush_i = ($urandom_range(99, 0) < 2);
         branch_redirect_i = ($urandom_range(99, 0) < 3);
         cyc();
      end
      set_idle(); branch_redirect_i = 1'b1; cyc(); set_idle();
      repeat (4) cyc();
      @(negedge clk); #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
